// File: rtl/ternary_scan_matcher.sv
// Ternary pattern-table scanner.
// A START request latches the input word, then the entries of a writable table of HI/LO/OUT
// ternary entries are checked one per cycle. MODE 0 ORs the OUT field of every matching entry.
// MODE 1 stops at the first matching entry. The result is published once START is released.
module ternary_scan_matcher #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned OUT_W  = 4,
    parameter int unsigned DEPTH  = 8,
    localparam int unsigned ADDR_W = $clog2(DEPTH),
    localparam int unsigned E      = 2 * DATA_W + OUT_W
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              START,
    input  logic              MODE,
    input  logic [DATA_W-1:0] I,
    input  logic              WE,
    input  logic [ADDR_W-1:0] WADDR,
    input  logic [E-1:0]      WDATA,
    output logic [OUT_W-1:0]  O,
    output logic [ADDR_W:0]   HIT_CNT,
    output logic              VALID,
    output logic              BUSY
);

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {StIdle, StLatch, StScan, StWait} state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   in_r_q, in_r_d;
    logic                mode_r_q, mode_r_d;
    logic [OUT_W-1:0]    acc_q, acc_d;
    logic [ADDR_W:0]     cnt_q, cnt_d;
    logic [ADDR_W-1:0]   mar_q, mar_d;
    logic [OUT_W-1:0]    o_q, o_d;
    logic [ADDR_W:0]     hit_cnt_q, hit_cnt_d;
    logic                valid_q, valid_d;
    logic [E-1:0]        tbl_q [DEPTH];

    logic [E-1:0]        entry;
    logic [DATA_W-1:0]   ent_hi, ent_lo, bit_ok;
    logic [OUT_W-1:0]    ent_out;
    logic                hit;
    logic                tbl_we;

    // Entry currently addressed by the scan, decoded into its three fields
    assign entry   = tbl_q[mar_q];
    assign ent_hi  = entry[E-1 -: DATA_W];
    assign ent_lo  = entry[DATA_W+OUT_W-1 -: DATA_W];
    assign ent_out = entry[OUT_W-1:0];
    // HI/LO = 11 don't care, 10 needs a 1, 01 needs a 0, 00 never matches
    assign bit_ok  = (ent_lo & ~in_r_q) | (ent_hi & in_r_q) | (ent_hi & ent_lo);
    assign hit     = &bit_ok;

    // Writes land only while idle and only for addresses inside the table
    assign tbl_we  = (state_q == StIdle) && WE && (32'(WADDR) < DEPTH);

    assign O       = o_q;
    assign HIT_CNT = hit_cnt_q;
    assign VALID   = valid_q;
    assign BUSY    = (state_q != StIdle);

    // Table storage; reset clears every entry to the never-match encoding
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < int'(DEPTH); i++) tbl_q[i] <= '0;
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (tbl_we && (WADDR == ADDR_W'(i))) tbl_q[i] <= WDATA;
            end
        end
    end

    // State and datapath registers
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q   <= StIdle;
            in_r_q    <= '0;
            mode_r_q  <= 1'b0;
            acc_q     <= '0;
            cnt_q     <= '0;
            mar_q     <= '0;
            o_q       <= '0;
            hit_cnt_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_r_q    <= in_r_d;
            mode_r_q  <= mode_r_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            mar_q     <= mar_d;
            o_q       <= o_d;
            hit_cnt_q <= hit_cnt_d;
            valid_q   <= valid_d;
        end
    end

    // Next-state and datapath update for the latch/scan/wait sequence
    always_comb begin
        state_d   = state_q;
        in_r_d    = in_r_q;
        mode_r_d  = mode_r_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        mar_d     = mar_q;
        o_d       = o_q;
        hit_cnt_d = hit_cnt_q;
        valid_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (START) state_d = StLatch;
            end
            StLatch: begin
                in_r_d   = I;
                mode_r_d = MODE;
                acc_d    = '0;
                cnt_d    = '0;
                mar_d    = '0;
                state_d  = StScan;
            end
            StScan: begin
                if (hit && mode_r_q) begin
                    acc_d   = ent_out;
                    cnt_d   = (ADDR_W + 1)'(1);
                    state_d = StWait;
                end else begin
                    if (hit) begin
                        acc_d = acc_q | ent_out;
                        cnt_d = cnt_q + (ADDR_W + 1)'(1);
                    end
                    if (mar_q == LastAddr) state_d = StWait;
                    else                   mar_d   = mar_q + ADDR_W'(1);
                end
            end
            StWait: begin
                // Publish is held off for as long as the host keeps START high
                if (!START) begin
                    o_d       = acc_q;
                    hit_cnt_d = cnt_q;
                    valid_d   = 1'b1;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: doc/ternary_scan_matcher.md
# ternary_scan_matcher

Parametrised ternary pattern-table scanner. On START it latches an input word and walks a writable table of DEPTH ternary entries. In mode 0 it ORs the output field of every matching entry; in mode 1 it stops at the first match. It publishes the result, plus a match count, once START is released. It is the configurable, loadable-table successor to the team's fixed-ROM 8-entry matcher. It sits as a small control/lookup slave under a host that loads the table and drives START.

## Interface
- DATA_W, 8, input/pattern width (>=1)
- OUT_W, 4, output field width (>=1)
- DEPTH, 8, table entries (>=2); ADDR_W = clog2(DEPTH), derived localparam
- Entry width E = 2*DATA_W+OUT_W; layout HI=[E-1:DATA_W+OUT_W], LO=[DATA_W+OUT_W-1:OUT_W], OUT=[OUT_W-1:0]
- CLOCK  in  1  clock, all logic on rising edge
- RESET  in  1  reset, asynchronous, active-high
- START  in  1  request; level-sampled
- MODE  in  1  0 = OR-accumulate all matches, 1 = first-match priority
- I  in  DATA_W  input word to classify
- WE  in  1  table write strobe
- WADDR  in  ADDR_W  table write address
- WDATA  in  E  table write data
- O  out  OUT_W  published result, registered
- HIT_CNT  out  ADDR_W+1  number of matching entries, registered
- VALID  out  1  one-cycle pulse when O/HIT_CNT update
- BUSY  out  1  high whenever state != IDLE

## Operation
- Per-bit match: bit b matches iff (LO[b]&~IN[b]) | (HI[b]&IN[b]) | (HI[b]&LO[b]).
  - HI/LO = 11: don't care. 10: IN must be 1. 01: IN must be 0. 00: never match.
- An entry matches iff all DATA_W bits match.
- States: IDLE, LATCH, SCAN, WAIT.
  - IDLE: START=1 -> LATCH.
  - LATCH: IN_R<=I, MODE_R<=MODE, ACC<=0, CNT<=0, MAR<=0 -> SCAN.
  - SCAN: evaluate entry MAR against IN_R, one entry per cycle.
    - On match in mode 0: ACC|=OUT, CNT+=1.
    - On match in mode 1: ACC<=OUT, CNT<=1, go to WAIT.
    - With no early exit: MAR==DEPTH-1 -> WAIT, else MAR+=1.
  - WAIT: START=0 -> O<=ACC, HIT_CNT<=CNT, VALID<=1, go to IDLE. START=1 -> hold.
- Table writes: table[WADDR]<=WDATA, only when WE=1 in IDLE.
  - WE in any other state is ignored.
  - WADDR>=DEPTH is ignored.
- WE and START in the same IDLE cycle: the write takes effect, and the scan sees the new entry.
- MODE and I are sampled only in LATCH; changes mid-scan have no effect.
- HIT_CNT cannot overflow (max DEPTH fits ADDR_W+1 bits). MAR wraps never; its terminal value is DEPTH-1.
- O and HIT_CNT hold their last published values until the next publish.
- Reset values: state IDLE, O=0, HIT_CNT=0, VALID=0, BUSY=0, IN_R/ACC/CNT/MAR=0.
  - All table entries reset to 0, so every entry never matches.
- RESET mid-operation: immediate return to reset values. The pending result is discarded and no VALID is issued.

## Timing
- Edge e0: START sampled 1 in IDLE. e1: LATCH. e2..e(1+DEPTH): SCAN entries 0..DEPTH-1.
- Mode 0: earliest publish at e(2+DEPTH), if START=0 then; VALID is high for the cycle after that edge.
- Mode 1: match at entry k exits at e(2+k); earliest publish at e(3+k). With no match, same as mode 0.
- START held high delays publish indefinitely; publish occurs on the first WAIT edge with START=0.
- BUSY rises after e0 and falls after the publish edge. A new START is accepted in the cycle after VALID.

## Test plan
- Reset, then START pulse with I=0x3C and the cleared table (DATA_W=8, OUT_W=4, DEPTH=8) -> O=0x0, HIT_CNT=0, VALID one cycle at e10; O/HIT_CNT/VALID/BUSY are all 0 during reset.
- Load entry0={HI 0xFF, LO 0xFF, OUT 0x1}, entry3={0xA5,0x5A,0x8}, entry7={0xF0,0xFF,0x4}; MODE=0.
  - I=0xA5 -> O=0x9, HIT_CNT=2.
  - I=0x50 -> O=0x5, HIT_CNT=2.
  - I=0x51 -> O=0x1, HIT_CNT=1.
- Same table, MODE=1, I=0xA5, START for one cycle -> O=0x1, HIT_CNT=1, VALID after e3, BUSY low after e3.
- MODE=0, START held high for 20 cycles -> no VALID until the first edge with START=0; then exactly one VALID with the correct O. O/HIT_CNT keep their prior values meanwhile.
- Write rules:
  - WE during SCAN changes nothing; the rerun gives the same result.
  - With DEPTH=6, WE with WADDR=7 is ignored.
  - WE+START in the same cycle writing entry0={0xFF,0xFF,0x2} -> that run includes OUT 0x2.
- Assert RESET mid-SCAN at e5 -> outputs 0 and no VALID. After release, a fresh START completes normally with the now-cleared table -> O=0x0.
